// File: rtl/schedule.sv
// Issue stage: scoreboard of 2-bit in-flight counters per GPR; holds RAW/saturating hazards.
// Latency: 1 cycle check->schedule; STALL is combinational; MEM_WAIT freezes the output slot.
module schedule (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        MEM_WAIT,
    input  logic        CHECK_ACCEPT,
    input  logic [31:0] CHECK_PC,
    input  logic [16:0] CHECK_OPCODE,
    input  logic [4:0]  CHECK_RD,
    input  logic [4:0]  CHECK_RS1,
    input  logic [4:0]  CHECK_RS2,
    input  logic [11:0] CHECK_CSR,
    input  logic [31:0] CHECK_IMM,
    input  logic        WB_VALID,
    input  logic [4:0]  WB_RD,
    output logic        STALL,
    output logic        SCHEDULE_VALID,
    output logic [31:0] SCHEDULE_PC,
    output logic [16:0] SCHEDULE_OPCODE,
    output logic [4:0]  SCHEDULE_RD,
    output logic [4:0]  SCHEDULE_RS1,
    output logic [4:0]  SCHEDULE_RS2,
    output logic [11:0] SCHEDULE_CSR,
    output logic [31:0] SCHEDULE_IMM
);

    typedef struct packed {
        logic [31:0] pc;
        logic [16:0] opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] csr;
        logic [31:0] imm;
    } sched_t;

    logic [31:1][1:0] cnt_q, cnt_d;
    logic [31:0]      busy_vec;
    logic [31:0]      sat_vec;
    logic             hazard;
    logic             issue;
    logic             inc;
    logic             dec;
    sched_t           out_q, out_d;
    logic             vld_q, vld_d;

    // Bit 0 of both vectors stays 0 so x0 never creates a hazard.
    always_comb begin
        busy_vec = '0;
        sat_vec  = '0;
        for (int i = 1; i < 32; i++) begin
            busy_vec[i] = |cnt_q[i];
            sat_vec[i]  = &cnt_q[i];
        end
    end

    assign hazard = busy_vec[CHECK_RS1] | busy_vec[CHECK_RS2] | sat_vec[CHECK_RD];
    assign STALL  = CHECK_ACCEPT & hazard & ~FLUSH;
    assign issue  = CHECK_ACCEPT & ~hazard & ~MEM_WAIT & ~FLUSH;

    // A same-cycle increment and decrement on one register cancel out.
    always_comb begin
        cnt_d = cnt_q;
        inc   = 1'b0;
        dec   = 1'b0;
        if (FLUSH) begin
            cnt_d = '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                inc = issue && (CHECK_RD == 5'(i));
                dec = WB_VALID && (WB_RD == 5'(i)) && busy_vec[i];
                if (inc && !dec) begin
                    cnt_d[i] = cnt_q[i] + 2'd1;
                end else if (dec && !inc) begin
                    cnt_d[i] = cnt_q[i] - 2'd1;
                end
            end
        end
    end

    always_comb begin
        vld_d = vld_q;
        out_d = out_q;
        if (FLUSH || (!MEM_WAIT && !issue)) begin
            vld_d = 1'b0;
            out_d = '0;
        end else if (issue) begin
            vld_d = 1'b1;
            out_d = '{pc: CHECK_PC, opcode: CHECK_OPCODE, rd: CHECK_RD, rs1: CHECK_RS1,
                      rs2: CHECK_RS2, csr: CHECK_CSR, imm: CHECK_IMM};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
            vld_q <= 1'b0;
            out_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            out_q <= out_d;
        end
    end

    assign SCHEDULE_VALID  = vld_q;
    assign SCHEDULE_PC     = out_q.pc;
    assign SCHEDULE_OPCODE = out_q.opcode;
    assign SCHEDULE_RD     = out_q.rd;
    assign SCHEDULE_RS1    = out_q.rs1;
    assign SCHEDULE_RS2    = out_q.rs2;
    assign SCHEDULE_CSR    = out_q.csr;
    assign SCHEDULE_IMM    = out_q.imm;

endmodule

// File: doc/schedule.md
SCHEDULE -- requirements
Module: schedule

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset; state is reset while RST=0.
- FLUSH  in  1  pipeline flush request.
- MEM_WAIT  in  1  global memory hold.
- CHECK_ACCEPT  in  1  the check-stage slot holds a valid instruction.
- CHECK_PC  in  32  instruction PC.
- CHECK_OPCODE  in  17  decoded opcode.
- CHECK_RD / CHECK_RS1 / CHECK_RS2  in  5 each  register indices.
- CHECK_CSR  in  12  CSR address.
- CHECK_IMM  in  32  immediate.
- WB_VALID  in  1  a register write retires this cycle.
- WB_RD  in  5  destination of the retiring write.
- STALL  out  1  combinational hold request to the upstream stages.
- SCHEDULE_VALID  out  1  the output slot holds an issued instruction.
- SCHEDULE_PC / SCHEDULE_OPCODE / SCHEDULE_RD / SCHEDULE_RS1 / SCHEDULE_RS2 / SCHEDULE_CSR / SCHEDULE_IMM  out  32/17/5/5/5/12/32  registered copy of the issued instruction.
REQ-002 The block SHALL have no parameters; widths are fixed as listed.

Function
REQ-003 The block SHALL keep a scoreboard of 31 two-bit in-flight counters cnt[1..31]; x0 has no counter and is never busy.
REQ-004 busy(r) SHALL be (r!=0 && cnt[r]!=0), evaluated on the current-cycle counter values, with no bypass from a same-cycle WB_VALID.
REQ-005 hazard SHALL be busy(CHECK_RS1) || busy(CHECK_RS2) || (CHECK_RD!=0 && cnt[CHECK_RD]==3).
REQ-006 STALL SHALL be CHECK_ACCEPT && hazard && !FLUSH.
REQ-007 issue SHALL be CHECK_ACCEPT && !hazard && !MEM_WAIT && !FLUSH.
REQ-008 On issue, the output registers SHALL capture all CHECK_* fields and set SCHEDULE_VALID=1 on the next edge, giving a latency of one cycle.
REQ-009 When MEM_WAIT=1 and FLUSH=0, all output registers SHALL hold their values.
REQ-010 When there is no issue, MEM_WAIT=0 and FLUSH=0, the output SHALL become a bubble: SCHEDULE_VALID=0 and all fields 0.
REQ-011 On issue with CHECK_RD!=0, cnt[CHECK_RD] SHALL increment by 1.
REQ-012 On WB_VALID with WB_RD!=0 and cnt[WB_RD]!=0, cnt[WB_RD] SHALL decrement by 1.
REQ-013 A WB_VALID to a zero counter, or to WB_RD=0, SHALL be ignored.
REQ-014 When an increment and a decrement hit the same register in one cycle, the counter SHALL be unchanged; counters SHALL never wrap (REQ-005 prevents increments beyond 3).
REQ-015 Scoreboard writebacks SHALL be processed regardless of MEM_WAIT.
REQ-016 On FLUSH, all counters SHALL clear to 0 and the output SHALL become a bubble on the next edge; FLUSH has priority over MEM_WAIT and issue.
REQ-017 WB_VALID in the same cycle as FLUSH SHALL be discarded.

Reset
REQ-018 While RST=0, SCHEDULE_VALID and every SCHEDULE_* output SHALL be 0 and every cnt[] SHALL be 0, asynchronously.
REQ-019 STALL SHALL be 0 during reset while CHECK_ACCEPT=0.
REQ-020 After RST deasserts, the first issue SHALL be possible on the first rising edge.

Verification
REQ-021 Reset mid-operation: cnt[5]=2 and SCHEDULE_VALID=1, drive RST=0 between edges -> outputs and counters read 0 immediately.
REQ-022 RAW hazard:
- Issue RD=5, then present RS1=5 -> STALL=1 and a bubble on the output.
- Then WB_VALID, WB_RD=5 -> STALL=0 the cycle after the WB edge, and the instruction issues one cycle later.
REQ-023 Counter saturation: issue three instructions with RD=7 and no WB, then present a fourth with RD=7 -> STALL=1 until one WB to x7 occurs.
REQ-024 Simultaneous events: issue RD=3 while WB_VALID with WB_RD=3 and cnt[3]=1 -> cnt[3] stays 1; RS1=0 or RD=0 never stalls.
REQ-025 MEM_WAIT: MEM_WAIT=1 with CHECK_ACCEPT=1 and no hazard -> outputs hold and counters unchanged except for WB; a WB_RD=9 during MEM_WAIT still decrements cnt[9].
REQ-026 FLUSH: FLUSH=1 with MEM_WAIT=1 and cnt[4]=2 -> next cycle SCHEDULE_VALID=0 and cnt[4]=0; a later WB_RD=4 is ignored.
